// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches from instruction RAM and hands
// each instruction with its PC to the decoder over a valid/ready handshake.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module ifu #(
   parameter int unsigned                ADDR_WIDTH = 32,
   parameter int unsigned                INST_WIDTH = `INST_WIDTH,
   parameter logic [ADDR_WIDTH-1:0]      RST_PC     = 32'h8000_0000
) (
   input  logic                  i_sys_clk,
   input  logic                  i_sys_rst,
   output logic                  o_sys_valid,
   input  logic                  i_sys_ready,
   output logic [ADDR_WIDTH-1:0] o_ifu_pc,
   output logic [INST_WIDTH-1:0] o_ifu_inst,
   output logic                  o_ifu_ram_rd_en,
   output logic [ADDR_WIDTH-1:0] o_ifu_ram_addr,
   input  logic                  i_ram_rd_valid,
   input  logic [INST_WIDTH-1:0] i_ram_inst,
   input  logic                  i_jmp_en,
   input  logic [ADDR_WIDTH-1:0] i_jmp_pc,
   output logic                  o_ifu_misalign
);

   localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d, tgt_q, tgt_d, jmp_tgt;
   logic [INST_WIDTH-1:0]   inst_q, inst_d;
   logic                    flush_q, flush_d, mis_q, mis_d;

   assign jmp_tgt = {i_jmp_pc[ADDR_WIDTH-1:2], 2'b00};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      inst_d  = inst_q;
      flush_d = flush_q;
      mis_d   = i_jmp_en & (i_jmp_pc[1:0] != 2'b00);
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (i_jmp_en) pc_d = jmp_tgt;
         end
         S_REQ: begin
            if (i_ram_rd_valid) begin
               // A response to a request made before a redirect is stale: drop it
               if (i_jmp_en) begin
                  pc_d    = jmp_tgt;
                  flush_d = 1'b0;
               end else if (flush_q) begin
                  pc_d    = tgt_q;
                  flush_d = 1'b0;
               end else begin
                  inst_d  = i_ram_inst;
                  state_d = S_HOLD;
               end
            end else if (i_jmp_en) begin
               flush_d = 1'b1;
               tgt_d   = jmp_tgt;
            end
         end
         S_HOLD: begin
            if (i_jmp_en) begin
               pc_d    = jmp_tgt;
               state_d = S_REQ;
            end else if (i_sys_ready) begin
               pc_d    = pc_q + ADDR_WIDTH'(4);
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         state_q <= S_IDLE;
         pc_q    <= RST_PC;
         tgt_q   <= '0;
         inst_q  <= NOP;
         flush_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         inst_q  <= inst_d;
         flush_q <= flush_d;
         mis_q   <= mis_d;
      end
   end

   assign o_sys_valid     = (state_q == S_HOLD);
   assign o_ifu_ram_rd_en = (state_q == S_REQ);
   assign o_ifu_ram_addr  = pc_q;
   assign o_ifu_pc        = pc_q;
   assign o_ifu_inst      = inst_q;
   assign o_ifu_misalign  = mis_q;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios then random traffic checked against an
// instruction-stream model (expected next PC, RAM contents as a function).
module tb_ifu;
   localparam logic [31:0] RST = 32'h8000_0000;

   logic        clk = 1'b0, rst = 1'b1;
   logic        valid, ready = 1'b0, rd_en, ram_valid = 1'b0, jmp = 1'b0, mis;
   logic [31:0] pc, inst, addr, ram_inst = '0, jmp_pc = '0;

   ifu dut (
      .i_sys_clk(clk), .i_sys_rst(rst), .o_sys_valid(valid), .i_sys_ready(ready),
      .o_ifu_pc(pc), .o_ifu_inst(inst), .o_ifu_ram_rd_en(rd_en), .o_ifu_ram_addr(addr),
      .i_ram_rd_valid(ram_valid), .i_ram_inst(ram_inst), .i_jmp_en(jmp),
      .i_jmp_pc(jmp_pc), .o_ifu_misalign(mis)
   );

   always #5 clk = ~clk;

   int          nchk = 0, nfail = 0, ndlv = 0, ram_cnt = 0, ram_lat = 0;
   bit          rnd_mode = 1'b0;
   logic [31:0] exp_pc = RST;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // RAM contents: a bijective scramble of the address, with a fixed word at RST
   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == RST) return 32'h0000_a0b7;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   // Called at negedge with ready/jmp set; drives RAM, updates model, advances one cycle
   task automatic cycle();
      logic pv, pr, pj, prd, pval, emis;
      logic [31:0] ppc, pinst, paddr;
      if (rd_en) begin
         ram_valid = (ram_cnt >= ram_lat);
         ram_inst  = mem(addr);
      end else begin
         ram_valid = rnd_mode && ($urandom_range(0, 3) == 0);
         ram_inst  = $urandom;
      end
      if (valid && ready) begin
         check("dlv_pc", pc, exp_pc);
         check("dlv_inst", inst, mem(exp_pc));
         ndlv++;
         if (!jmp) exp_pc = exp_pc + 32'd4;
      end
      if (jmp) exp_pc = {jmp_pc[31:2], 2'b00};
      emis = jmp && (jmp_pc[1:0] != 2'b00);
      pv = valid; pr = ready; pj = jmp; ppc = pc; pinst = inst;
      prd = rd_en; pval = ram_valid; paddr = addr;
      if (rd_en) begin
         ram_cnt = ram_valid ? 0 : ram_cnt + 1;
         if (ram_valid && rnd_mode) ram_lat = $urandom_range(0, 3);
      end
      @(posedge clk);
      @(negedge clk);
      check("misalign", {31'b0, mis}, {31'b0, emis});
      if (pv && !pr && !pj) begin
         check("hold_valid", {31'b0, valid}, 32'd1);
         check("hold_pc", pc, ppc);
         check("hold_inst", inst, pinst);
      end
      if (prd && !pval) begin
         check("req_rden", {31'b0, rd_en}, 32'd1);
         check("req_addr", addr, paddr);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; jmp = 1'b0;
      #1;
      check("rst_valid", {31'b0, valid}, 32'd0);
      check("rst_rden", {31'b0, rd_en}, 32'd0);
      check("rst_inst", inst, 32'h0000_0013);
      check("rst_mis", {31'b0, mis}, 32'd0);
      check("rst_addr", addr, RST);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; exp_pc = RST; ram_cnt = 0;
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      // 1: zero-wait fetch after reset
      ram_lat = 0; ready = 1'b1;
      check("t1_idle_rden", {31'b0, rd_en}, 32'd0);
      cycle();
      check("t1_rden", {31'b0, rd_en}, 32'd1);
      check("t1_addr", addr, RST);
      cycle();
      check("t1_valid", {31'b0, valid}, 32'd1);
      check("t1_inst", inst, 32'h0000_a0b7);
      check("t1_pc", pc, RST);
      cycle();
      check("t1_next_addr", addr, 32'h8000_0004);
      // 2: decoder stall in HOLD
      ready = 1'b0;
      cycle();
      for (int i = 0; i < 5; i++) begin
         check("t2_valid", {31'b0, valid}, 32'd1);
         check("t2_rden", {31'b0, rd_en}, 32'd0);
         cycle();
      end
      ready = 1'b1;
      cycle();
      check("t2_next_addr", addr, 32'h8000_0008);
      // 3: slow RAM
      ram_lat = 3;
      for (int i = 0; i < 4; i++) begin
         check("t3_rden", {31'b0, rd_en}, 32'd1);
         check("t3_addr", addr, 32'h8000_0008);
         cycle();
      end
      check("t3_valid", {31'b0, valid}, 32'd1);
      cycle();
      check("t3_next_addr", addr, 32'h8000_000c);
      // 4: redirect while a request is outstanding
      ram_lat = 2; jmp = 1'b1; jmp_pc = 32'h8000_0100;
      cycle();
      jmp = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("t4_no_valid", {31'b0, valid}, 32'd0);
         cycle();
      end
      check("t4_no_valid_end", {31'b0, valid}, 32'd0);
      check("t4_addr", addr, 32'h8000_0100);
      check("t4_rden", {31'b0, rd_en}, 32'd1);
      // 5: redirect together with a handshake
      ram_lat = 0;
      cycle();
      jmp = 1'b1; jmp_pc = 32'h8000_0200;
      cycle();
      jmp = 1'b0;
      check("t5_addr", addr, 32'h8000_0200);
      // 6: misaligned target, PC wrap, mid-HOLD reset
      jmp = 1'b1; jmp_pc = 32'h8000_0102;
      cycle();
      jmp = 1'b0;
      check("t6_mis_addr", addr, 32'h8000_0100);
      cycle();
      ready = 1'b0; jmp = 1'b1; jmp_pc = 32'hFFFF_FFFC;
      cycle();
      jmp = 1'b0;
      check("t6_wrap_req", addr, 32'hFFFF_FFFC);
      cycle();
      ready = 1'b1;
      cycle();
      check("t6_wrap_addr", addr, 32'h0000_0000);
      cycle();
      check("t6_hold_valid", {31'b0, valid}, 32'd1);
      do_reset();
      cycle();
      check("t6_restart_addr", addr, RST);
      check("t6_restart_rden", {31'b0, rd_en}, 32'd1);
      // random traffic
      rnd_mode = 1'b1; ndlv = 0;
      for (int i = 0; i < 3000; i++) begin
         ready = ($urandom_range(0, 3) != 0);
         jmp   = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 1) == 0) jmp_pc = $urandom;
         else jmp_pc = RST + {20'b0, 10'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 399) == 0) do_reset();
         else cycle();
      end
      jmp = 1'b0;
      check("rnd_progress", {31'b0, (ndlv >= 200)}, 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule
